match_sequencer: RTL
====================

Name: match_sequencer

Overview:
- Takes a snapshot of an 87-bit match/request vector and issues the 1-based index of every set bit, one at a time, lowest bit first.
- Uses the same index encoding as the team's 87-input priority encoder: bit k maps to index k+1, and 127 means "no index".
- Indices are handed to a downstream consumer over a valid/ready handshake. A done pulse fires when the snapshot is exhausted.
- Sits between the match-vector producer and the per-index processing stage, so the whole vector is serviced rather than only its highest-priority bit.

Parameters:
- WIDTH, 87, number of request bits in the vector (index range 1..WIDTH).
- IDX_W, 7, width of the index and count outputs; must satisfy 2^IDX_W-1 > WIDTH.
- NONE_IDX, 127, index code driven when no valid index is present.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  capture req_vec and begin sequencing; honoured only in IDLE.
- abort  input  1  synchronous cancel of the current sequence.
- req_vec  input  WIDTH  request/match vector, sampled only on an accepted start.
- idx_out  output  IDX_W  1-based index of the current bit; NONE_IDX when idx_valid=0.
- idx_valid  output  1  idx_out holds a valid index.
- idx_ready  input  1  consumer accepts idx_out when idx_valid && idx_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when all captured bits have been issued.
- count  output  IDX_W  indices accepted in the current/last sequence; cleared on an accepted start.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-low; clock port is clk, reset port is rst_n.
- Reset values: state=IDLE, pending=0, idx_out=127, idx_valid=0, busy=0, done=0, count=0.
- All outputs are registered.
- State machine:
  - IDLE: on start=1, pending<=req_vec, count<=0, go to SCAN. start=0: remain in IDLE.
  - SCAN: if pending==0, done<=1 and go to DONE. Otherwise find the lowest set bit k: idx_out<=k+1, idx_valid<=1, clear pending[k], go to ISSUE.
  - ISSUE: hold idx_out and idx_valid stable until idx_ready=1. On that handshake edge: idx_valid<=0, idx_out<=127, count<=count+1, go to SCAN.
  - DONE: done is high for exactly this cycle; then done<=0 and go to IDLE.
- Latency:
  - start sampled at edge E gives SCAN in cycle E+1; first idx_valid (or done, for an empty vector) is visible in cycle E+2.
  - Each index after the first needs one SCAN cycle after its handshake, so maximum throughput is 1 index per 2 cycles.
- Order: strictly ascending bit position. Bit 0 gives index 1; bit 86 gives index 87.
- Snapshot semantics: req_vec changes after capture have no effect. start while busy=1 is ignored, with no re-capture and no error.
- Backpressure: idx_ready may stay low indefinitely; idx_out must not change while idx_valid=1 and idx_ready=0. idx_ready while idx_valid=0 is ignored.
- Abort: abort=1 in any non-IDLE state, on the next edge:
  - state<=IDLE, pending<=0, idx_valid<=0, idx_out<=127, done<=0.
  - count keeps its current value.
  - abort in IDLE has no effect. abort has priority over start and over a simultaneous handshake; that index is not counted.
- Reset mid-operation: rst_n=0 at any edge forces all reset values, overriding abort, start and handshake.
- Width rules:
  - count is at most WIDTH (87) and never wraps.
  - Index arithmetic is IDX_W bits unsigned. The value 0 is never driven; 127 is never a valid index.

Test Plan:
- Single bit: req_vec bit 0 only, start at E, idx_ready=1 → idx_valid with idx_out=1 in cycle E+2; done in E+4; count=1.
- Multi bit: bits {0,5,86} set, idx_ready=1 → idx_out sequence 1, 6, 87, each valid for 1 cycle, 1 cycle apart; done after 87 is issued; count=3.
- Empty vector: req_vec=0, start at E → no idx_valid; done=1 only in cycle E+2; count=0; busy=0 in E+3.
- Backpressure and snapshot: bits {3,4} set; hold idx_ready=0 for 5 cycles while toggling req_vec and pulsing start → idx_out stays 4 throughout; sequence is 4 then 5; count=2.
- Abort: all 87 bits set; abort asserted on the edge where idx_out=10 handshakes → idx_valid=0 and idx_out=127 next cycle; no done; count=9; a new start then works normally.
- Full vector and reset: all 87 bits set, idx_ready=1 → indices 1..87 in order, count=87, one done pulse. A repeat run with rst_n=0 mid-sequence gives all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/match_sequencer.sv
// -----------------------------------------------------------------------------
// match_sequencer
//
// Captures a snapshot of a WIDTH-bit request/match vector and issues the
// 1-based index of every set bit, lowest bit first, over a valid/ready
// handshake. A one-cycle done pulse marks the end of the snapshot.
// Index encoding: bit k -> index k+1, NONE_IDX means "no index".
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      capture req_vec and begin sequencing (honoured only in IDLE)
//   abort      synchronous cancel of the current sequence (ignored in IDLE)
//   req_vec    request vector, sampled only on an accepted start
//   idx_out    current 1-based index, NONE_IDX when idx_valid=0
//   idx_valid  idx_out holds a valid index
//   idx_ready  consumer accepts idx_out when idx_valid && idx_ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse when all captured bits have been issued
//   count      indices accepted in the current/last sequence
// -----------------------------------------------------------------------------
module match_sequencer #(
    parameter int WIDTH    = 87,
    parameter int IDX_W    = 7,
    parameter int NONE_IDX = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] req_vec,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] count
);

    localparam logic [IDX_W-1:0] NONE    = IDX_W'(NONE_IDX);
    localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   idx_out_q, idx_out_d;
    logic               idx_valid_q, idx_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   count_q, count_d;

    // Lowest set bit of the pending snapshot. Scanning from the top down
    // lets the last hit (the lowest bit) win; the one-hot mask is used to
    // clear exactly that bit once it is issued.
    logic               low_found;
    logic [IDX_W-1:0]   low_pos;
    logic [WIDTH-1:0]   low_onehot;

    always_comb begin
        low_found  = 1'b0;
        low_pos    = '0;
        low_onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_found     = 1'b1;
                low_pos       = IDX_W'(i);
                low_onehot    = '0;
                low_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state / output logic
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        idx_out_d   = idx_out_q;
        idx_valid_d = idx_valid_q;
        done_d      = 1'b0;
        count_d     = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d = req_vec;
                    count_d   = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!low_found) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_out_d   = low_pos + IDX_W'(1);
                    idx_valid_d = 1'b1;
                    pending_d   = pending_q & ~low_onehot;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // idx_out/idx_valid hold until the consumer takes the index
                if (idx_ready) begin
                    idx_valid_d = 1'b0;
                    idx_out_d   = NONE;
                    if (count_q != MAX_CNT)
                        count_d = count_q + IDX_W'(1);
                    state_d = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything above, including a same-cycle handshake
        // (that index is not counted). count keeps its value.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            pending_d   = '0;
            idx_valid_d = 1'b0;
            idx_out_d   = NONE;
            done_d      = 1'b0;
            count_d     = count_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            idx_out_q   <= NONE;
            idx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_out_q   <= idx_out_d;
            idx_valid_q <= idx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign idx_out   = idx_out_q;
    assign idx_valid = idx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule
